// File: rtl/map_pkg.sv
// ============================================================================
// map_pkg: tile-map constants and helpers shared by the map, player and arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

package map_pkg;

    localparam int TYPE_W   = 3;
    localparam int COORD_W  = 6;
    localparam int MAP_COLS = 40;
    localparam int MAP_ROWS = 30;

    typedef logic [TYPE_W-1:0]  tile_t;
    typedef logic [COORD_W-1:0] coord_t;

    localparam tile_t TILE_FLOOR = 3'd0;
    localparam tile_t TILE_WALL  = 3'd1;

    function automatic logic out_of_map(input coord_t x, input coord_t y);
        return (x >= coord_t'(MAP_COLS)) || (y >= coord_t'(MAP_ROWS));
    endfunction

endpackage

`default_nettype wire

// File: rtl/rr_arbiter.sv
// ============================================================================
// rr_arbiter: round-robin pick among the low-priority requesters 1..NREQ-1.
// Rev 1.0
// ============================================================================
`default_nettype none

module rr_arbiter #(
    parameter int NREQ = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [NREQ-2:0] valid_i,   // bit k belongs to requester k+1
    input  logic            advance_i,
    output logic [NREQ-2:0] pick_o,
    output logic            any_o
);

    localparam int NL = NREQ - 1;
    localparam int PW = (NL > 1) ? $clog2(NL) : 1;

    logic [PW-1:0] ptr_q;
    logic [PW-1:0] ptr_d;
    logic [PW-1:0] sel;

    // Scan starting at the pointer so the requester after the last winner goes first.
    always_comb begin
        pick_o = '0;
        any_o  = 1'b0;
        sel    = ptr_q;
        for (int k = 0; k < NL; k++) begin
            if (!any_o && valid_i[(int'(ptr_q) + k) % NL]) begin
                pick_o[(int'(ptr_q) + k) % NL] = 1'b1;
                any_o = 1'b1;
                sel   = PW'((int'(ptr_q) + k) % NL);
            end
        end
    end

    always_comb begin
        ptr_d = ptr_q;
        if (advance_i) begin
            ptr_d = (sel == PW'(NL - 1)) ? '0 : sel + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

endmodule

`default_nettype wire

// File: rtl/map_query_arbiter.sv
// ============================================================================
// map_query_arbiter: shares the map read port, fixed-priority display plus
// round-robin movers with a starvation guard; 3-cycle in-order pipeline.
// Rev 1.0
// ============================================================================
`default_nettype none

module map_query_arbiter
    import map_pkg::*;
#(
    parameter int NREQ       = 3,
    parameter int STARVE_MAX = 15
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [NREQ-1:0]         req_valid,
    input  logic [NREQ*COORD_W-1:0] req_x,
    input  logic [NREQ*COORD_W-1:0] req_y,
    output logic [NREQ-1:0]         req_ready,
    output logic [NREQ-1:0]         rsp_valid,
    output logic [TYPE_W-1:0]       rsp_type,
    output logic                    mem_en,
    output logic [COORD_W-1:0]      mem_x,
    output logic [COORD_W-1:0]      mem_y,
    input  logic [TYPE_W-1:0]       mem_type,
    output logic                    busy
);

    localparam int ID_W  = $clog2(NREQ);
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    typedef struct packed {
        logic            vld;
        logic [ID_W-1:0] id;
        logic            oob;
    } tag_t;

    logic [NREQ-2:0]  rr_pick;
    logic             rr_any;
    logic             starved;
    logic             lo_grant;
    logic [NREQ-1:0]  grant;
    logic             accept;
    logic [ID_W-1:0]  acc_id;
    coord_t           acc_x;
    coord_t           acc_y;
    logic             acc_oob;

    logic [CNT_W-1:0] starve_q, starve_d;
    tag_t             s1_q, s1_d;
    tag_t             s2_q;
    logic             mem_en_q;
    coord_t           mem_x_q, mem_y_q;
    logic [NREQ-1:0]  rsp_valid_q;
    tile_t            rsp_type_q;

    rr_arbiter #(
        .NREQ (NREQ)
    ) u_rr (
        .clk       (clk),
        .rst_n     (rst),
        .valid_i   (req_valid[NREQ-1:1]),
        .advance_i (lo_grant),
        .pick_o    (rr_pick),
        .any_o     (rr_any)
    );

    assign starved = (starve_q >= CNT_W'(STARVE_MAX));

    // A starved mover jumps ahead of the display requester for exactly one grant.
    always_comb begin
        grant    = '0;
        lo_grant = 1'b0;
        if (starved && rr_any) begin
            grant[NREQ-1:1] = rr_pick;
            lo_grant        = 1'b1;
        end else if (req_valid[0]) begin
            grant[0] = 1'b1;
        end else if (rr_any) begin
            grant[NREQ-1:1] = rr_pick;
            lo_grant        = 1'b1;
        end
    end

    assign req_ready = rst ? grant : '0;
    assign accept    = |req_ready;

    always_comb begin
        acc_id = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                acc_id = ID_W'(i);
            end
        end
        acc_x   = req_x[acc_id*COORD_W +: COORD_W];
        acc_y   = req_y[acc_id*COORD_W +: COORD_W];
        acc_oob = out_of_map(acc_x, acc_y);
        s1_d.vld = accept;
        s1_d.id  = acc_id;
        s1_d.oob = acc_oob;
    end

    always_comb begin
        starve_d = starve_q;
        if (lo_grant) begin
            starve_d = '0;
        end else if (rr_any && !starved) begin
            starve_d = starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            starve_q    <= '0;
            s1_q        <= '0;
            s2_q        <= '0;
            mem_en_q    <= 1'b0;
            mem_x_q     <= '0;
            mem_y_q     <= '0;
            rsp_valid_q <= '0;
            rsp_type_q  <= '0;
        end else begin
            starve_q <= starve_d;
            s1_q     <= s1_d;
            s2_q     <= s1_q;
            // Out-of-map slots skip the read and leave the address untouched.
            mem_en_q <= accept && !acc_oob;
            if (accept && !acc_oob) begin
                mem_x_q <= acc_x;
                mem_y_q <= acc_y;
            end
            rsp_valid_q <= s2_q.vld ? (NREQ'(1) << s2_q.id) : '0;
            if (s2_q.vld) begin
                rsp_type_q <= s2_q.oob ? TILE_WALL : mem_type;
            end
        end
    end

    assign mem_en    = mem_en_q;
    assign mem_x     = mem_x_q;
    assign mem_y     = mem_y_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_type  = rsp_type_q;
    assign busy      = s1_q.vld | s2_q.vld | (|rsp_valid_q);

endmodule

`default_nettype wire

// File: tb/tb_map_query_arbiter.sv
// ============================================================================
// tb_map_query_arbiter: directed and randomized checks of map_query_arbiter.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_map_query_arbiter;
    import map_pkg::*;

    localparam int NREQ = 3;
    localparam int SM   = 15;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  req_valid;
    logic [17:0] req_x, req_y;
    logic [2:0]  req_ready, rsp_valid;
    logic [2:0]  rsp_type;
    logic        mem_en;
    logic [5:0]  mem_x, mem_y;
    logic [2:0]  mem_type;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] map_m [0:63][0:63];
    int m_ptr;
    int m_wait;

    typedef struct {
        int         due;
        logic       vld;
        int         id;
        logic [2:0] typ;
    } rsp_e;

    typedef struct {
        int         due;
        logic       en;
        logic [5:0] x;
        logic [5:0] y;
    } mem_e;

    map_query_arbiter #(.NREQ(NREQ), .STARVE_MAX(SM)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_x     (req_x),
        .req_y     (req_y),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_type  (rsp_type),
        .mem_en    (mem_en),
        .mem_x     (mem_x),
        .mem_y     (mem_y),
        .mem_type  (mem_type),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Synchronous map: data one cycle after the strobe, junk otherwise.
    always @(posedge clk) mem_type <= mem_en ? map_m[mem_x][mem_y] : 3'd7;

    // Reference arbitration: display first unless a mover has waited SM cycles.
    function automatic int model_grant(input logic [2:0] v);
        logic lo;
        int   rr;
        lo = v[1] | v[2];
        rr = -1;
        if (v[m_ptr])          rr = m_ptr;
        else if (v[3 - m_ptr]) rr = 3 - m_ptr;
        if (lo && m_wait >= SM) return rr;
        if (v[0])               return 0;
        if (lo)                 return rr;
        return -1;
    endfunction

    function automatic void model_update(input int g, input logic [2:0] v);
        if (g >= 1) begin
            m_ptr  = (g == 2) ? 1 : g + 1;
            m_wait = 0;
        end else if (v[1] | v[2]) begin
            m_wait = m_wait + 1;
        end
    endfunction

    task automatic set_req(input int i, input int x, input int y);
        req_x[i*6 +: 6] = 6'(x);
        req_y[i*6 +: 6] = 6'(y);
    endtask

    task automatic do_reset();
        rst       = 1'b0;
        req_valid = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst    = 1'b1;
        m_ptr  = 1;
        m_wait = 0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 3; i++) set_req(i, i + 2, i + 3);
        req_valid = 3'b111;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_tests++;
            if (req_ready !== 3'b001) begin
                n_fail++;
                $display("FAIL reset_pre_grant: got %b expected 001", req_ready);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if ({req_ready, rsp_valid, rsp_type} !== 9'd0) begin
            n_fail++;
            $display("FAIL reset_async_rsp: got ready=%b rsp=%b type=%0d expected all 0",
                     req_ready, rsp_valid, rsp_type);
        end
        n_tests++;
        if ({mem_en, mem_x, mem_y, busy} !== 14'd0) begin
            n_fail++;
            $display("FAIL reset_async_mem: got en=%b x=%0d y=%0d busy=%b expected all 0",
                     mem_en, mem_x, mem_y, busy);
        end
        req_valid = '0;
        @(negedge clk);
        rst = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            n_tests++;
            if (rsp_valid !== 3'b000 || busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_no_rsp: got rsp=%b busy=%b expected 000/0", rsp_valid, busy);
            end
        end
        @(posedge clk);
        #1;
        req_valid = 3'b011;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 3'b001) begin
            n_fail++;
            $display("FAIL reset_first_grant: got %b expected 001", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 3'b010;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 3'b010) begin
            n_fail++;
            $display("FAIL reset_second_grant: got %b expected 010", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
    endtask

    task automatic test_single();
        do_reset();
        map_m[5][7] = 3'd4;
        set_req(1, 5, 7);
        req_valid = 3'b010;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 3'b010) begin
            n_fail++;
            $display("FAIL single_grant: got %b expected 010", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        @(negedge clk);
        n_tests++;
        if ({mem_en, mem_x, mem_y, busy} !== {1'b1, 6'd5, 6'd7, 1'b1}) begin
            n_fail++;
            $display("FAIL single_mem: got en=%b x=%0d y=%0d busy=%b expected 1,5,7,1",
                     mem_en, mem_x, mem_y, busy);
        end
        @(negedge clk);
        n_tests++;
        if (mem_en !== 1'b0 || rsp_valid !== 3'b000) begin
            n_fail++;
            $display("FAIL single_t2: got en=%b rsp=%b expected 0/000", mem_en, rsp_valid);
        end
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 3'b010 || rsp_type !== 3'd4) begin
            n_fail++;
            $display("FAIL single_rsp: got rsp=%b type=%0d expected 010/4", rsp_valid, rsp_type);
        end
        @(negedge clk);
        n_tests++;
        if (rsp_valid !== 3'b000 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_idle: got rsp=%b busy=%b expected 000/0", rsp_valid, busy);
        end
    endtask

    task automatic test_oob();
        logic seen_en;
        logic seen_early;
        do_reset();
        map_m[40][0] = 3'd6;
        set_req(2, 40, 0);
        req_valid = 3'b100;
        seen_en    = 1'b0;
        seen_early = 1'b0;
        @(negedge clk);
        n_tests++;
        if (req_ready !== 3'b100) begin
            n_fail++;
            $display("FAIL oob_grant: got %b expected 100", req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = '0;
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk);
            seen_en = seen_en | mem_en;
            if (k < 3) seen_early = seen_early | (|rsp_valid);
        end
        n_tests++;
        if (rsp_valid !== 3'b100 || rsp_type !== TILE_WALL || seen_early !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_rsp: got rsp=%b type=%0d early=%b expected 100/%0d/0",
                     rsp_valid, rsp_type, seen_early, TILE_WALL);
        end
        n_tests++;
        if (seen_en !== 1'b0) begin
            n_fail++;
            $display("FAIL oob_mem_en: got %b expected 0", seen_en);
        end
    endtask

    task automatic test_round_robin();
        int         x1, y1, x2, y2;
        logic [2:0] exp_g, exp_r, exp_t;
        do_reset();
        x1 = $urandom_range(0, 39); y1 = $urandom_range(0, 29);
        x2 = $urandom_range(0, 39); y2 = $urandom_range(0, 29);
        set_req(1, x1, y1);
        set_req(2, x2, y2);
        req_valid = 3'b110;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (c < 8) begin
                exp_g = (c % 2 == 0) ? 3'b010 : 3'b100;
                n_tests++;
                if (req_ready !== exp_g) begin
                    n_fail++;
                    $display("FAIL rr_grant c=%0d: got %b expected %b", c, req_ready, exp_g);
                end
            end
            if (c >= 3) begin
                exp_r = (c >= 11) ? 3'b000 : (((c - 3) % 2 == 0) ? 3'b010 : 3'b100);
                exp_t = ((c - 3) % 2 == 0) ? map_m[x1][y1] : map_m[x2][y2];
                n_tests++;
                if (rsp_valid !== exp_r || (exp_r != 0 && rsp_type !== exp_t)) begin
                    n_fail++;
                    $display("FAIL rr_rsp c=%0d: got %b/%0d expected %b/%0d",
                             c, rsp_valid, rsp_type, exp_r, exp_t);
                end
            end
            @(posedge clk);
            #1;
            if (c == 7) req_valid = '0;
        end
    endtask

    task automatic test_starvation();
        logic [2:0] exp_g;
        do_reset();
        set_req(0, 1, 1);
        set_req(1, 2, 2);
        req_valid = 3'b011;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            exp_g = (c % 16 == 0) ? 3'b010 : 3'b001;
            n_tests++;
            if (req_ready !== exp_g) begin
                n_fail++;
                $display("FAIL starve_grant cycle=%0d: got %b expected %b", c, req_ready, exp_g);
            end
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_throughput(input int ncyc, input bit rand_mode);
        rsp_e       rq[$];
        mem_e       mq[$];
        rsp_e       re;
        mem_e       me;
        int         g, idle;
        logic [2:0] exp_ready, exp_rv, exp_rt;
        logic       exp_en, exp_busy, oob;
        logic [5:0] x, y;
        do_reset();
        idle = 0;
        for (int i = 0; i < 3; i++) begin
            set_req(i, $urandom_range(0, 39), $urandom_range(0, 29));
            req_valid[i] = rand_mode ? 1'($urandom_range(0, 1)) : 1'b1;
        end
        for (int c = 0; c < ncyc + 80; c++) begin
            @(negedge clk);
            g = model_grant(req_valid);
            exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
            n_tests++;
            if (req_ready !== exp_ready) begin
                n_fail++;
                $display("FAIL tp_grant c=%0d: got %b expected %b", c, req_ready, exp_ready);
            end
            exp_rv = 3'b000;
            exp_rt = 3'd0;
            if (rq.size() > 0 && rq[0].due == c) begin
                re = rq.pop_front();
                if (re.vld) begin
                    exp_rv = 3'(1 << re.id);
                    exp_rt = re.typ;
                end
            end
            n_tests++;
            if (rsp_valid !== exp_rv || (exp_rv != 0 && rsp_type !== exp_rt)) begin
                n_fail++;
                $display("FAIL tp_rsp c=%0d: got %b/%0d expected %b/%0d",
                         c, rsp_valid, rsp_type, exp_rv, exp_rt);
            end
            exp_en = 1'b0;
            me.x = '0;
            me.y = '0;
            if (mq.size() > 0 && mq[0].due == c) begin
                me = mq.pop_front();
                exp_en = me.en;
            end
            n_tests++;
            if (mem_en !== exp_en || (exp_en && (mem_x !== me.x || mem_y !== me.y))) begin
                n_fail++;
                $display("FAIL tp_mem c=%0d: got %b (%0d,%0d) expected %b (%0d,%0d)",
                         c, mem_en, mem_x, mem_y, exp_en, me.x, me.y);
            end
            exp_busy = (exp_rv != 0);
            foreach (rq[k]) exp_busy = exp_busy | rq[k].vld;
            n_tests++;
            if (busy !== exp_busy) begin
                n_fail++;
                $display("FAIL tp_busy c=%0d: got %b expected %b", c, busy, exp_busy);
            end
            if (g >= 0) begin
                x   = req_x[g*6 +: 6];
                y   = req_y[g*6 +: 6];
                oob = (x >= 6'd40) || (y >= 6'd30);
                rq.push_back('{due: c + 3, vld: 1'b1, id: g, typ: oob ? TILE_WALL : map_m[x][y]});
                mq.push_back('{due: c + 1, en: !oob, x: x, y: y});
            end else begin
                rq.push_back('{due: c + 3, vld: 1'b0, id: 0, typ: 3'd0});
                mq.push_back('{due: c + 1, en: 1'b0, x: 6'd0, y: 6'd0});
            end
            model_update(g, req_valid);
            @(posedge clk);
            #1;
            if (g >= 0) req_valid[g] = 1'b0;
            for (int i = 0; i < 3; i++) begin
                if (!req_valid[i] && c + 1 < ncyc && (!rand_mode || $urandom_range(0, 2) != 0)) begin
                    if (rand_mode) set_req(i, $urandom_range(0, 44), $urandom_range(0, 33));
                    else           set_req(i, $urandom_range(0, 39), $urandom_range(0, 29));
                    req_valid[i] = 1'b1;
                end
            end
            if (c >= ncyc && req_valid == 3'b000) idle++;
            if (idle > 4) break;
        end
        n_tests++;
        if (req_valid !== 3'b000) begin
            n_fail++;
            $display("FAIL tp_drain: pending %b still waiting, expected 000", req_valid);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst       = 1'b0;
        req_valid = '0;
        req_x     = '0;
        req_y     = '0;
        for (int i = 0; i < 64; i++)
            for (int j = 0; j < 64; j++)
                map_m[i][j] = 3'($urandom_range(0, 7));
        test_reset();
        test_single();
        test_oob();
        test_round_robin();
        test_starvation();
        test_throughput(100, 1'b0);
        test_throughput(200, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
